// File: rtl/i2c_pkg.sv
// Shared constants and types for the I2C bus event decoder.
package i2c_pkg;
    localparam int FILTER_LEN_DEFAULT = 3;
    localparam int BITS_PER_BYTE      = 8;
    localparam int ACK_BIT_IDX        = 8;
    // Wide enough for the full FILTER_LEN range of 1..15.
    localparam int FILT_CNT_W         = 4;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_t;
endpackage

// File: rtl/i2c_bus_event_decoder_if.sv
// Raw I2C lines in, filtered levels and decoded bus events out.
// Every *_valid / *_pulse output is a one-cycle strobe with no ready; the consumer must take it that cycle.
interface i2c_bus_event_decoder_if;
    import i2c_pkg::*;

    logic       sda;
    logic       scl;
    logic       sda_f;
    logic       scl_f;
    logic       start_pulse;
    logic       stop_pulse;
    logic       bit_valid;
    logic       bit_val;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       ack_valid;
    logic       ack;
    logic [3:0] bit_cnt;
    logic       bus_busy;
    bus_state_t bus_state;

    modport master (
        output sda, scl,
        input  sda_f, scl_f, start_pulse, stop_pulse, bit_valid, bit_val,
               byte_valid, byte_data, ack_valid, ack, bit_cnt, bus_busy, bus_state
    );

    modport slave (
        input  sda, scl,
        output sda_f, scl_f, start_pulse, stop_pulse, bit_valid, bit_val,
               byte_valid, byte_data, ack_valid, ack, bit_cnt, bus_busy, bus_state
    );
endinterface

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchronizer followed by a persistence filter for one I2C line.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_filt
);
    localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILTER_LEN - 1);

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_filt;
    logic [FILT_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_filt  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // The level flips on the FILTER_LEN-th consecutive disagreeing cycle.
            if (r_sync2 != r_filt) begin
                if (r_cnt == CNT_LAST) begin
                    r_filt <= r_sync2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_filt = r_filt;
endmodule

// File: rtl/i2c_bus_event_decoder.sv
// Decodes START/STOP, data bits, bytes and ACK from filtered SDA/SCL levels.
module i2c_bus_event_decoder
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    i2c_bus_event_decoder_if.slave  bus
);
    localparam logic [3:0] LAST_DATA_IDX = 4'(BITS_PER_BYTE - 1);
    localparam logic [3:0] ACK_IDX       = 4'(ACK_BIT_IDX);

    logic       w_sda_f;
    logic       w_scl_f;
    logic       w_scl_rise;
    logic       w_scl_hold_hi;
    logic       w_sda_fall;
    logic       w_sda_rise;

    bus_state_t r_state;
    logic       r_sda_prev;
    logic       r_scl_prev;
    logic [6:0] r_shift;
    logic [3:0] r_bit_cnt;
    logic       r_start_pulse;
    logic       r_stop_pulse;
    logic       r_bit_valid;
    logic       r_bit_val;
    logic       r_byte_valid;
    logic [7:0] r_byte_data;
    logic       r_ack_valid;
    logic       r_ack;

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .reset(reset), .i_raw(bus.sda), .o_filt(w_sda_f)
    );

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .reset(reset), .i_raw(bus.scl), .o_filt(w_scl_f)
    );

    // START/STOP need SCL high in both this and the previous cycle, so an SDA
    // change coinciding with an SCL rise is treated as data, not a condition.
    assign w_scl_rise    =  w_scl_f & ~r_scl_prev;
    assign w_scl_hold_hi =  w_scl_f &  r_scl_prev;
    assign w_sda_fall    = ~w_sda_f &  r_sda_prev;
    assign w_sda_rise    =  w_sda_f & ~r_sda_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= BUS_IDLE;
            r_sda_prev    <= 1'b1;
            r_scl_prev    <= 1'b1;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_start_pulse <= 1'b0;
            r_stop_pulse  <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_bit_val     <= 1'b0;
            r_byte_valid  <= 1'b0;
            r_byte_data   <= '0;
            r_ack_valid   <= 1'b0;
            r_ack         <= 1'b0;
        end else begin
            r_sda_prev    <= w_sda_f;
            r_scl_prev    <= w_scl_f;
            r_start_pulse <= 1'b0;
            r_stop_pulse  <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_byte_valid  <= 1'b0;
            r_ack_valid   <= 1'b0;

            if (w_scl_hold_hi && w_sda_fall) begin
                r_start_pulse <= 1'b1;
                r_state       <= BUS_BUSY;
                r_bit_cnt     <= '0;
                r_shift       <= '0;
            end else if (w_scl_hold_hi && w_sda_rise) begin
                r_stop_pulse  <= 1'b1;
                r_state       <= BUS_IDLE;
                r_bit_cnt     <= '0;
            end else if (w_scl_rise && (r_state == BUS_BUSY)) begin
                if (r_bit_cnt == ACK_IDX) begin
                    r_ack_valid <= 1'b1;
                    r_ack       <= ~w_sda_f;
                    r_bit_cnt   <= '0;
                end else begin
                    r_bit_valid <= 1'b1;
                    r_bit_val   <= w_sda_f;
                    r_shift     <= {r_shift[5:0], w_sda_f};
                    r_bit_cnt   <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == LAST_DATA_IDX) begin
                        r_byte_valid <= 1'b1;
                        r_byte_data  <= {r_shift, w_sda_f};
                    end
                end
            end
        end
    end

    assign bus.sda_f       = w_sda_f;
    assign bus.scl_f       = w_scl_f;
    assign bus.start_pulse = r_start_pulse;
    assign bus.stop_pulse  = r_stop_pulse;
    assign bus.bit_valid   = r_bit_valid;
    assign bus.bit_val     = r_bit_val;
    assign bus.byte_valid  = r_byte_valid;
    assign bus.byte_data   = r_byte_data;
    assign bus.ack_valid   = r_ack_valid;
    assign bus.ack         = r_ack;
    assign bus.bit_cnt     = r_bit_cnt;
    assign bus.bus_busy    = (r_state == BUS_BUSY);
    assign bus.bus_state   = r_state;
endmodule

// File: doc/i2c_bus_event_decoder.md
I2C_BUS_EVENT_DECODER -- requirements
Module: i2c_bus_event_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 3, consecutive clk cycles a synchronized line must differ from its filtered level before the filtered level changes (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sda  input  1  raw I2C data line, asynchronous to clk.
REQ-005 scl  input  1  raw I2C clock line, asynchronous to clk.
REQ-006 sda_f  output  1  synchronized, glitch-filtered sda; feeds the downstream pattern FSM.
REQ-007 scl_f  output  1  synchronized, glitch-filtered scl; feeds the downstream pattern FSM.
REQ-008 start_pulse  output  1  one-cycle START or repeated-START indication.
REQ-009 stop_pulse  output  1  one-cycle STOP indication.
REQ-010 bit_valid  output  1  one-cycle strobe per data bit sampled on an scl_f rising edge.
REQ-011 bit_val  output  1  sampled bit value, valid with bit_valid.
REQ-012 byte_valid  output  1  one-cycle strobe when 8 data bits have been assembled.
REQ-013 byte_data  output  8  assembled byte, MSB first; held until the next byte_valid.
REQ-014 ack_valid  output  1  one-cycle strobe on the 9th bit of a frame.
REQ-015 ack  output  1  1 = ACK (sda_f low on 9th bit), 0 = NACK; held until the next ack_valid.
REQ-016 bit_cnt  output  4  bit position within the current frame, 0..8.
REQ-017 bus_busy  output  1  high from START until STOP.

Function
REQ-018 Each raw line SHALL pass through a 2-flop synchronizer and then a glitch filter: filtered level updates only after the synchronized value differs from it for FILTER_LEN consecutive cycles; any agreeing cycle clears the filter counter.
REQ-019 Edge detection SHALL compare filtered levels with their values from the previous cycle; all event outputs are registered and assert exactly one cycle after the filtered change, each for exactly one cycle.
REQ-020 Total latency: a clean raw edge stable from cycle t SHALL appear on sda_f/scl_f at t+2+FILTER_LEN and on the event pulse at t+3+FILTER_LEN.
REQ-021 START: sda_f falls while scl_f is high and unchanged; SHALL assert start_pulse, set bus_busy, clear bit_cnt and the shift register; repeated START mid-frame is handled identically.
REQ-022 STOP: sda_f rises while scl_f is high and unchanged; SHALL assert stop_pulse, clear bus_busy and bit_cnt; a partial byte is discarded with no byte_valid.
REQ-023 Data bit: scl_f rising edge while bus_busy; SHALL assert bit_valid with bit_val = sda_f; if sda_f changes in the same cycle as scl_f rises, the new sda_f value is sampled and no START/STOP is reported.
REQ-024 bit_cnt 0..7: bit shifts into byte_data LSB, bit_cnt increments; at bit_cnt 7 byte_valid asserts in the same cycle as bit_valid with the complete byte.
REQ-025 bit_cnt 8: ack_valid asserts with ack = ~sda_f; bit_cnt wraps to 0.
REQ-026 scl_f rising edges while bus_busy is low SHALL produce no strobes and leave bit_cnt at 0.
REQ-027 Falling edges of scl_f SHALL generate no events.

Reset
REQ-028 Synchronizer flops, sda_f and scl_f SHALL reset to 1 (idle bus); filter counters, bit_cnt, byte_data, all pulses, ack and bus_busy reset to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; no event is reported in the cycle after reset deasserts if the raw lines are high.

Structure
REQ-030 Package i2c_pkg SHALL hold FILTER_LEN default, BITS_PER_BYTE = 8, ACK_BIT_IDX = 8 and the filter counter width.
REQ-031 Sub-module i2c_glitch_filter (synchronizer + filter, one line) SHALL be instanced twice, once per line.

Verification
REQ-032 START, byte 0xA0 driven with clean edges, sda low on 9th clock -> start_pulse once, 8 bit_valid, byte_valid with byte_data = 0xA0, ack_valid with ack = 1, bit_cnt back to 0.
REQ-033 sda glitch low for FILTER_LEN-1 = 2 cycles while scl high -> no start_pulse, sda_f stays 1; same glitch for 3 cycles -> start_pulse.
REQ-034 START, 3 data bits 1,0,1, repeated START -> second start_pulse, bit_cnt = 0, no byte_valid; following byte 0x5C reported correctly.
REQ-035 Byte 0xFF with sda high on 9th clock, then STOP -> ack_valid with ack = 0, stop_pulse, bus_busy falls to 0.
REQ-036 reset asserted after 5 bits of a frame, then scl pulses without START -> all outputs at reset values, no bit_valid until a new START.
